kbd_tx: RTL and testbench
=========================

// Module: kbd_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Sits beside the keyboard receiver on the same open-drain ps2_clk/ps2_data pins, behind a 2-register I/O slot.
//  Bus side: ctrl/status at addr2=0, tx data at addr2=1. Zero wait states. Level irq when transmitter ready.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles ps2_clk is held low before start (>=100us at 50MHz)
//  TIMEOUT_CYCLES  750000  max clk cycles from clock release to ACK (15ms at 50MHz)
// PORTS
//  clk          in   1  system clock; single clock domain
//  reset        in   1  synchronous, active-high reset
//  ps2_clk      in   1  PS/2 clock pin level (asynchronous)
//  ps2_data     in   1  PS/2 data pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clk low, 0 = release
//  ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release
//  en           in   1  bus access to this device
//  wr           in   1  1 = write, 0 = read
//  addr2        in   1  0 = ctrl/status, 1 = tx data
//  data_in      in   8  write data
//  data_out     out  8  read data (combinational from addr2)
//  wt           out  1  wait; constant 0
//  irq          out  1  ien & rdy
//  tx_busy      out  1  1 while not IDLE; receiver gates off its input with it
// BEHAVIOUR
//  Registers: status {4'b0, busy, err, ien, rdy}; data = last accepted tx byte.
//  Reset: rdy=1, ien=0, err=0, data=0x00, state=IDLE, both oe=0, irq=0, tx_busy=0.
//  Write addr2=0: ien<=data_in[1]; err<=data_in[2] (write 0 clears). rdy/busy are read-only.
//  Write addr2=1 in IDLE: data<=data_in, rdy<=0, err<=0, start INHIBIT next cycle.
//  Write addr2=1 when not IDLE: ignored; data, rdy, err unchanged.
//  Reads have no side effects. wt=0.
//  Pin input: each pin goes through a 2-FF synchroniser. A falling edge is a sync'd ps2_clk with
//   previous=1 and current=0. Outputs are registered and change 1 cycle after the detected edge.
//  FSM:
//   IDLE: both oe=0.
//   INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles; in the last cycle data_oe=1 (start bit).
//   START: clk_oe=0, data_oe=1. Start the timeout counter. Clear bitcnt to 0.
//   BITS: on each falling edge, bitcnt++ and the next bit is driven:
//    edges 1..8 drive d0..d7, LSB first (data_oe = ~bit).
//    edge 9 drives odd parity: data_oe = ~(~^data).
//    edge 10 releases data (stop bit = 1).
//   ACK: on edge 11, sample sync'd ps2_data; 0 = ACK, 1 = err<=1. Go to WAITIDLE.
//   WAITIDLE: wait until sync'd ps2_clk=1 and ps2_data=1, then rdy<=1 and go to IDLE.
//  Timeout: counter runs in START..WAITIDLE.
//   On reaching TIMEOUT_CYCLES: err<=1, rdy<=1, both oe<=0, state IDLE (same cycle).
//   Timeout has priority over a coincident clock edge.
//  Reset mid-transfer: both lines are released on the next clk edge. The partial frame is abandoned.
//  A write to addr2=0 coinciding with completion: the hardware setting of err/rdy wins for those bits.
//   ien still takes data_in[1].
// TESTING
//  (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, device model clocks 40-cycle period, ACKs on edge 11)
//  write 0xED to addr2=1:
//   -> clk_oe high 8 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
//   -> status reads 0x01 after done, err=0.
//  write 0x00 then 0x01:
//   -> parity bits 1 then 0;
//   -> rdy=0 and tx_busy=1 throughout each frame.
//  write ctrl 0x02, send 0xF4:
//   -> irq low during frame, rises with rdy at frame end;
//   -> write ctrl 0x00 -> irq=0.
//  device never clocks:
//   -> after 2000 cycles from clock release: status 0x05 (err, rdy), both oe=0;
//   -> write ctrl 0x00 clears err.
//  device omits ACK (data high on edge 11):
//   -> err=1, rdy=1;
//  second write during a frame:
//   -> ignored; data reads the first byte.
//  assert reset at edge 5 of a frame:
//   -> oe=0 next cycle, status 0x01, data 0x00.

Source files
------------

// File: rtl/kbd_tx_if.sv
// Register-slot bus between a CPU-side master and the PS/2 transmitter.
// The master drives the access strobes and write data; the slave returns read data, wait and irq.
interface kbd_tx_if;
   logic       en;
   logic       wr;
   logic       addr2;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       wt;
   logic       irq;

   modport master (output en, output wr, output addr2, output data_in,
                   input data_out, input wt, input irq);
   modport slave  (input en, input wr, input addr2, input data_in,
                   output data_out, output wt, output irq);
endinterface

// File: rtl/kbd_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, then shifts one byte
// with odd parity on the device's clock and checks for the device's ACK.
module kbd_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      ps2_clk,
   input  logic      ps2_data,
   output logic      ps2_clk_oe,
   output logic      ps2_data_oe,
   output logic      tx_busy,
   kbd_tx_if.slave   bus
);

   localparam int IW = $clog2(INHIBIT_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] INH_LAST    = IW'(INHIBIT_CYCLES - 1);
   localparam logic [IW-1:0] INH_PRELAST = IW'(INHIBIT_CYCLES - 2);
   localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_START, S_BITS, S_ACK, S_WAITIDLE
   } state_t;

   state_t        r_state;
   logic [1:0]    r_clkSync;
   logic [1:0]    r_dataSync;
   logic          r_clkPrev;
   logic [IW-1:0] r_inhCnt;
   logic [TW-1:0] r_timeout;
   logic [3:0]    r_bitCnt;
   logic [7:0]    r_data;
   logic          r_rdy;
   logic          r_err;
   logic          r_ien;
   logic          r_clkOe;
   logic          r_dataOe;

   logic w_fall;
   logic w_timeout;
   logic w_busy;
   logic w_ctrlWr;
   logic w_dataWr;

   assign w_fall    = r_clkPrev & ~r_clkSync[1];
   assign w_timeout = (r_timeout == TO_LAST);
   assign w_busy    = (r_state != S_IDLE);
   assign w_ctrlWr  = bus.en & bus.wr & ~bus.addr2;
   assign w_dataWr  = bus.en & bus.wr & bus.addr2;

   // Synchronisers, register file and the transmit FSM share one clocked block so that the
   // hardware's own setting of err/rdy (assigned later) wins over a coincident ctrl write.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_clkSync  <= 2'b11;
         r_dataSync <= 2'b11;
         r_clkPrev  <= 1'b1;
         r_inhCnt   <= '0;
         r_timeout  <= '0;
         r_bitCnt   <= '0;
         r_data     <= 8'h00;
         r_rdy      <= 1'b1;
         r_err      <= 1'b0;
         r_ien      <= 1'b0;
         r_clkOe    <= 1'b0;
         r_dataOe   <= 1'b0;
      end else begin
         r_clkSync  <= {r_clkSync[0], ps2_clk};
         r_dataSync <= {r_dataSync[0], ps2_data};
         r_clkPrev  <= r_clkSync[1];

         if (w_ctrlWr) begin
            r_ien <= bus.data_in[1];
            r_err <= bus.data_in[2];
         end

         if (r_state != S_IDLE && r_state != S_INHIBIT) begin
            r_timeout <= r_timeout + 1'b1;
         end

         unique case (r_state)
            S_IDLE: begin
               if (w_dataWr) begin
                  r_data   <= bus.data_in;
                  r_rdy    <= 1'b0;
                  r_err    <= 1'b0;
                  r_clkOe  <= 1'b1;
                  r_dataOe <= 1'b0;
                  r_inhCnt <= '0;
                  r_state  <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               r_inhCnt <= r_inhCnt + 1'b1;
               if (r_inhCnt == INH_PRELAST) begin
                  r_dataOe <= 1'b1;
               end
               if (r_inhCnt == INH_LAST) begin
                  r_clkOe   <= 1'b0;
                  r_timeout <= '0;
                  r_bitCnt  <= '0;
                  r_state   <= S_START;
               end
            end
            default: begin
               // Timeout is checked first so it beats a falling edge in the same cycle.
               if (w_timeout) begin
                  r_err    <= 1'b1;
                  r_rdy    <= 1'b1;
                  r_clkOe  <= 1'b0;
                  r_dataOe <= 1'b0;
                  r_state  <= S_IDLE;
               end else if (r_state == S_WAITIDLE) begin
                  if (r_clkSync[1] && r_dataSync[1]) begin
                     r_rdy   <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else if (w_fall) begin
                  r_bitCnt <= r_bitCnt + 1'b1;
                  if (r_state == S_START) begin
                     r_dataOe <= ~r_data[0];
                     r_state  <= S_BITS;
                  end else if (r_state == S_BITS) begin
                     if (r_bitCnt < 4'd8) begin
                        r_dataOe <= ~r_data[r_bitCnt[2:0]];
                     end else if (r_bitCnt == 4'd8) begin
                        r_dataOe <= ^r_data;
                     end else begin
                        r_dataOe <= 1'b0;
                        r_state  <= S_ACK;
                     end
                  end else begin
                     if (r_dataSync[1]) begin
                        r_err <= 1'b1;
                     end
                     r_state <= S_WAITIDLE;
                  end
               end
            end
         endcase
      end
   end

   assign ps2_clk_oe   = r_clkOe;
   assign ps2_data_oe  = r_dataOe;
   assign tx_busy      = w_busy;
   assign bus.data_out = bus.addr2 ? r_data : {4'b0000, w_busy, r_err, r_ien, r_rdy};
   assign bus.wt       = 1'b0;
   assign bus.irq      = r_ien & r_rdy;

endmodule

// File: tb/tb_kbd_tx.sv
// Bench for kbd_tx: a behavioural PS/2 device on open-drain pins plus a register-level model
// of the status/data slot that is compared against the DUT on every cycle it is well defined.
module tb_kbd_tx;

   localparam int INH = 8;
   localparam int TO  = 2000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ps2_clk_oe;
   logic ps2_data_oe;
   logic tx_busy;
   logic devClkLow = 1'b0;
   logic devDataLow = 1'b0;
   logic ps2_clk;
   logic ps2_data;

   assign ps2_clk  = ~(ps2_clk_oe | devClkLow);
   assign ps2_data = ~(ps2_data_oe | devDataLow);

   kbd_tx_if bus ();

   kbd_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_busy     (tx_busy),
      .bus         (bus.slave)
   );

   always #5 clk = ~clk;

   int testCount = 0;
   int failCount = 0;

   bit         modelKnown = 1'b0;
   bit         expBusy;
   bit         expErr;
   bit         expIen;
   bit         expRdy;
   logic [7:0] expData;

   // Expected line levels for one frame, index 0 first: d0..d7, odd parity, stop.
   function automatic logic [9:0] expFrame(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         if (failCount <= 40)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Per-cycle comparison of everything the model knows about the register slot.
   always @(negedge clk) begin
      if (modelKnown && !reset) begin
         checkOutput("cyc_busy", tx_busy, expBusy);
         checkOutput("cyc_irq", bus.irq, expIen & expRdy);
         checkOutput("cyc_wt", bus.wt, 0);
         checkOutput("cyc_rdata", bus.data_out,
                     bus.addr2 ? expData : {4'b0000, expBusy, expErr, expIen, expRdy});
         if (!expBusy)
            checkOutput("cyc_oe_idle", {ps2_clk_oe, ps2_data_oe}, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic addr, input logic [7:0] val);
      bus.en = 1'b1; bus.wr = 1'b1; bus.addr2 = addr; bus.data_in = val;
      tick();
      bus.en = 1'b0; bus.wr = 1'b0; bus.addr2 = 1'b0;
      if (!addr) begin
         expIen = val[1];
         expErr = val[2];
      end else if (!expBusy) begin
         expData = val; expRdy = 1'b0; expErr = 1'b0; expBusy = 1'b1;
      end
   endtask

   task automatic busRead(input logic addr, output logic [7:0] val);
      bus.en = 1'b1; bus.wr = 1'b0; bus.addr2 = addr;
      #1 val = bus.data_out;
      tick();
      bus.en = 1'b0; bus.addr2 = 1'b0;
   endtask

   // Watches the inhibit period; returns 0 if the clock is never released.
   task automatic inhibitPhase(output bit ok);
      int highCnt = 0;
      logic firstD = 1'b1;
      logic lastD = 1'b0;
      while (ps2_clk_oe && highCnt < 100) begin
         if (highCnt == 0) firstD = ps2_data_oe;
         lastD = ps2_data_oe;
         highCnt++;
         tick();
      end
      ok = (highCnt < 100);
      checkOutput("inhibit_len", highCnt, INH);
      checkOutput("inhibit_first_data", firstD, 0);
      checkOutput("inhibit_last_data", lastD, 1);
      if (ok) checkOutput("start_bit", ps2_data_oe, 1);
   endtask

   // mode 0: normal ACK, 1: no ACK, 2: reset at edge 5, 3: second write during frame.
   task automatic runFrame(input logic [7:0] b, input int mode, output logic [9:0] frame);
      bit ok;
      logic [7:0] rd;
      frame = '0;
      applyStimulus(1'b1, b);
      inhibitPhase(ok);
      if (!ok) return;
      repeat (10) tick();
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) begin
            modelKnown = 1'b0;
            if (mode != 1) devDataLow = 1'b1;
            repeat (5) tick();
         end
         devClkLow = 1'b1;
         if (mode == 2 && k == 5) begin
            repeat (5) tick();
            modelKnown = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            checkOutput("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
            expBusy = 1'b0; expErr = 1'b0; expIen = 1'b0; expRdy = 1'b1; expData = 8'h00;
            busRead(1'b0, rd);
            checkOutput("rst_mid_status", rd, 8'h01);
            busRead(1'b1, rd);
            checkOutput("rst_mid_data", rd, 8'h00);
            modelKnown = 1'b1;
            devClkLow = 1'b0;
            repeat (10) tick();
            return;
         end
         if (mode == 3 && k == 3) begin
            applyStimulus(1'b1, ~b);
            repeat (18) tick();
         end else begin
            repeat (20) tick();
         end
         devClkLow = 1'b0;
         if (k <= 10) frame[k-1] = ps2_data;
         repeat (20) tick();
      end
      devDataLow = 1'b0;
      repeat (10) tick();
      expBusy = 1'b0;
      expRdy = 1'b1;
      if (mode == 1) expErr = 1'b1;
      modelKnown = 1'b1;
      checkOutput("frame_bits", frame, expFrame(b));
   endtask

   initial begin
      logic [9:0] frame;
      logic [7:0] rd;
      logic [7:0] b;
      logic       ien;
      bit         ok;

      bus.en = 1'b0; bus.wr = 1'b0; bus.addr2 = 1'b0; bus.data_in = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      expBusy = 1'b0; expErr = 1'b0; expIen = 1'b0; expRdy = 1'b1; expData = 8'h00;
      modelKnown = 1'b1;
      checkOutput("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      checkOutput("reset_busy", tx_busy, 0);
      checkOutput("reset_irq", bus.irq, 0);
      busRead(1'b0, rd); checkOutput("reset_status", rd, 8'h01);
      busRead(1'b1, rd); checkOutput("reset_data", rd, 8'h00);

      runFrame(8'hED, 0, frame);
      checkOutput("frame_ED", frame, 10'h3ED);
      busRead(1'b0, rd); checkOutput("status_after_ED", rd, 8'h01);

      runFrame(8'h00, 0, frame);
      checkOutput("frame_00", frame, 10'h300);
      runFrame(8'h01, 0, frame);
      checkOutput("frame_01", frame, 10'h201);

      applyStimulus(1'b0, 8'h02);
      runFrame(8'hF4, 0, frame);
      checkOutput("irq_after_F4", bus.irq, 1);
      applyStimulus(1'b0, 8'h00);
      checkOutput("irq_cleared", bus.irq, 0);

      // Device never clocks: the transmitter must give up on its own.
      applyStimulus(1'b1, 8'hAB);
      inhibitPhase(ok);
      if (ok) begin
         repeat (TO - 20) tick();
         checkOutput("timeout_not_early", tx_busy, 1);
         modelKnown = 1'b0;
         repeat (40) tick();
         expBusy = 1'b0; expRdy = 1'b1; expErr = 1'b1;
         modelKnown = 1'b1;
         checkOutput("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
         busRead(1'b0, rd); checkOutput("timeout_status", rd, 8'h05);
         applyStimulus(1'b0, 8'h00);
         busRead(1'b0, rd); checkOutput("timeout_err_cleared", rd, 8'h01);
      end

      runFrame(8'h55, 1, frame);
      busRead(1'b0, rd); checkOutput("noack_status", rd, 8'h05);
      applyStimulus(1'b0, 8'h00);

      runFrame(8'h3C, 3, frame);
      busRead(1'b1, rd); checkOutput("second_write_ignored", rd, 8'h3C);

      for (int i = 0; i < 6; i++) begin
         ien = 1'($urandom_range(0, 1));
         applyStimulus(1'b0, {5'b00000, 1'b0, ien, 1'b0});
         b = 8'($urandom);
         runFrame(b, 0, frame);
         busRead(1'b0, rd); checkOutput("rand_status", rd, {6'b000000, ien, 1'b1});
      end

      runFrame(8'hED, 2, frame);
      runFrame(8'hED, 0, frame);
      checkOutput("frame_after_reset", frame, 10'h3ED);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
